// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first asynchronous UART frame generator (start, 5-8 data, optional parity, 1-2 stop).
// Latency: the start bit reaches o_uart_tx on the edge after the accepting handshake; a frame is (1+D+P+S)*div cycles.
// Backpressure: o_user_tx_ready is only high in IDLE with CTS low; one byte per handshake, frame config latched at accept.
//
// Optional feature macro: UART_TX_BREAK_EN adds input i_break and the BREAK/MARK line-break sequence.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   i_user_tx_data/valid  byte and its valid; o_user_tx_ready accepts it
//   i_div_num             clock cycles per bit (0 behaves as 1)
//   i_data_bit            data bits per frame, clamped to 5..P_DATA_WIDTH
//   i_stop_bit            0/1 -> one stop bit, 2/3 -> two stop bits
//   i_check_bit           0/3 none, 1 odd, 2 even parity
//   i_uart_cts            high holds off the start of a new frame
//   o_uart_tx             serial line, idle high
//   o_tx_busy             high from handshake until the last stop bit ends
module uart_tx_serializer #(
    parameter int P_DIV_WIDTH  = 24,
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [P_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                    i_user_tx_valid,
    output logic                    o_user_tx_ready,
    input  logic [P_DIV_WIDTH-1:0]  i_div_num,
    input  logic [3:0]              i_data_bit,
    input  logic [1:0]              i_stop_bit,
    input  logic [1:0]              i_check_bit,
    input  logic                    i_uart_cts,
`ifdef UART_TX_BREAK_EN
    input  logic                    i_break,
`endif
    output logic                    o_uart_tx,
    output logic                    o_tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK  = 3'd5,
        S_MARK   = 3'd6
`endif
    } state_t;

    localparam logic [P_DIV_WIDTH-1:0] DIV_ONE  = P_DIV_WIDTH'(1);
    localparam logic [3:0]             MIN_BITS = 4'd5;
    localparam logic [3:0]             MAX_BITS = 4'(P_DATA_WIDTH);

    state_t                  state_q, state_d;
    logic [P_DIV_WIDTH-1:0]  baud_q, baud_d;
    logic [P_DIV_WIDTH-1:0]  div_q, div_d;
    logic [3:0]              bit_q, bit_d;
    logic [3:0]              dbits_q, dbits_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    stop2_q, stop2_d;
    logic                    par_en_q, par_en_d;
    logic                    par_q, par_d;
    logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic [P_DIV_WIDTH-1:0]  eff_div;
    logic [3:0]              eff_dbits;
    logic [P_DATA_WIDTH-1:0] data_mask;
    logic                    baud_done;
    logic                    accept;

    // Effective configuration seen at the accepting edge.
    always_comb begin
        eff_div = (i_div_num == '0) ? DIV_ONE : i_div_num;
        if (i_data_bit < MIN_BITS) begin
            eff_dbits = MIN_BITS;
        end else if (i_data_bit > MAX_BITS) begin
            eff_dbits = MAX_BITS;
        end else begin
            eff_dbits = i_data_bit;
        end
        data_mask = '0;
        for (int i = 0; i < P_DATA_WIDTH; i++) begin
            data_mask[i] = (4'(i) < eff_dbits);
        end
    end

    assign baud_done = (baud_q == (div_q - DIV_ONE));
    assign accept    = (state_q == S_IDLE) && i_user_tx_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_done ? '0 : (baud_q + DIV_ONE);
        div_d      = div_q;
        bit_d      = bit_q;
        dbits_d    = dbits_q;
        stop_cnt_d = stop_cnt_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (accept) begin
                    state_d    = S_START;
                    div_d      = eff_div;
                    bit_d      = '0;
                    dbits_d    = eff_dbits;
                    stop_cnt_d = 1'b0;
                    stop2_d    = (i_stop_bit >= 2'd2);
                    par_en_d   = (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
                    // Odd parity inverts the XOR so the ones-count including parity is odd.
                    par_d      = (^(i_user_tx_data & data_mask)) ^ (i_check_bit == 2'd1);
                    shift_d    = i_user_tx_data & data_mask;
                end
`ifdef UART_TX_BREAK_EN
                else if (i_break) begin
                    state_d = S_BREAK;
                    div_d   = eff_div;
                end
`endif
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == (dbits_q - 4'd1)) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (stop_cnt_q == stop2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                baud_d = '0;
                if (!i_break) begin
                    state_d    = S_MARK;
                    stop_cnt_d = 1'b0;
                end
            end
            S_MARK: begin
                // Two bit periods of mark after the break releases.
                if (baud_done) begin
                    if (stop_cnt_q) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line follows the current state one cycle later, so the start bit
        // lands on the edge after the handshake.
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_d = 1'b0;
`endif
            default:  tx_d = 1'b1;
        endcase

        // Ready/busy track the next state so back-to-back frames get a single idle cycle.
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) && !i_uart_cts;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            dbits_q    <= '0;
            stop_cnt_q <= 1'b0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            dbits_q    <= dbits_d;
            stop_cnt_q <= stop_cnt_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = ready_q;
    assign o_tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench; expected frames are queued at each handshake
// and a line monitor decodes TXD bit-by-bit against them.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_serializer;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        o_user_tx_ready;
    logic [23:0] div_num = 24'd4;
    logic [3:0]  data_bit = 4'd8;
    logic [1:0]  stop_bit = 2'd0;
    logic [1:0]  check_bit = 2'd0;
    logic        cts = 1'b0;
    logic        o_uart_tx;
    logic        o_tx_busy;

    always #5 clock = ~clock;

    uart_tx_serializer dut (
        .clock           (clock),
        .reset           (rst_n),
        .i_user_tx_data  (tx_data),
        .i_user_tx_valid (tx_valid),
        .o_user_tx_ready (o_user_tx_ready),
        .i_div_num       (div_num),
        .i_data_bit      (data_bit),
        .i_stop_bit      (stop_bit),
        .i_check_bit     (check_bit),
        .i_uart_cts      (cts),
        .o_uart_tx       (o_uart_tx),
        .o_tx_busy       (o_tx_busy)
    );

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    int     n_tests = 0;
    int     n_fail = 0;
    frame_t exp_q[$];
    frame_t cur;
    bit     in_frame = 0;
    bit     frame_bad = 0;
    int     pos = 0;
    int     idle_cnt = 0;
    int     last_gap = -1;
    int     frames_done = 0;

    // Reference frame: start 0, D data bits LSB first, optional parity, 1 or 2 stop bits.
    function automatic frame_t make_frame(input logic [7:0] data, input int dn, input int db,
                                          input int sb, input int cb);
        frame_t     f;
        int         d;
        int         n;
        logic       p;
        logic [7:0] sh;
        f.div  = (dn == 0) ? 1 : dn;
        d      = (db < 5) ? 5 : ((db > 8) ? 8 : db);
        f.bits = 16'h0000;
        n      = 1;
        p      = 1'b0;
        for (int i = 0; i < d; i++) begin
            sh = data >> i;
            if (sh[0]) f.bits = f.bits | (16'h0001 << n);
            p = p ^ sh[0];
            n++;
        end
        if (cb == 1) begin
            if (!p) f.bits = f.bits | (16'h0001 << n);
            n++;
        end else if (cb == 2) begin
            if (p) f.bits = f.bits | (16'h0001 << n);
            n++;
        end
        f.bits = f.bits | (16'h0001 << n);
        n++;
        if (sb >= 2) begin
            f.bits = f.bits | (16'h0001 << n);
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    // Line monitor: pops the expected frame at each start bit and checks every sample.
    always @(negedge clock) begin
        logic [15:0] tmp;
        if (!rst_n) begin
            in_frame = 0;
            idle_cnt = 0;
        end else begin
            if (!in_frame) begin
                if (o_uart_tx === 1'b0) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame: TXD low at %0t with no accepted byte", $time);
                    end else begin
                        cur       = exp_q.pop_front();
                        in_frame  = 1;
                        frame_bad = 0;
                        pos       = 0;
                        last_gap  = idle_cnt;
                    end
                end else begin
                    idle_cnt++;
                end
            end
            if (in_frame) begin
                tmp = cur.bits >> (pos / cur.div);
                if (o_uart_tx !== tmp[0] && !frame_bad) begin
                    frame_bad = 1;
                    n_fail++;
                    $display("FAIL frame_bit: frame %0d cycle %0d TXD=%b expected %b", frames_done, pos, o_uart_tx, tmp[0]);
                end
                pos++;
                if (pos == cur.nbits * cur.div) begin
                    in_frame = 0;
                    frames_done++;
                    idle_cnt = 0;
                end
            end
        end
    end

    // Offer a byte, queue its expected frame once the handshake is certain, drop valid after it.
    task automatic send(input logic [7:0] d);
        bit got;
        got      = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int t = 0; t < 300 && !got; t++) begin
            if (o_user_tx_ready === 1'b1) begin
                exp_q.push_back(make_frame(d, int'(div_num), int'(data_bit), int'(stop_bit), int'(check_bit)));
                got = 1;
            end
            @(negedge clock);
        end
        tx_valid = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready never high for byte %h", d);
        end
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (frames_done < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: frames_done=%0d expected %0d", frames_done, target);
        end
    endtask

    task automatic busy_len(input string name, input int expected);
        int cnt;
        cnt = 0;
        while (o_tx_busy === 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clock);
        end
        n_tests++;
        if (cnt !== expected) begin
            n_fail++;
            $display("FAIL %s: busy high %0d cycles, expected %0d", name, cnt, expected);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_tests += 3;
        if (o_uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: %b expected 1", o_uart_tx); end
        if (o_user_tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: %b expected 0", o_user_tx_ready); end
        if (o_tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b expected 0", o_tx_busy); end
        rst_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (o_user_tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: %b expected 1", o_user_tx_ready); end
    endtask

    task automatic test_basic_8n1();
        int base;
        base = frames_done;
        div_num = 24'd4; data_bit = 4'd8; stop_bit = 2'd0; check_bit = 2'd0;
        send(8'h55);
        // Config changes after acceptance must not disturb the frame in flight.
        div_num = 24'd7; data_bit = 4'd5; check_bit = 2'd2;
        busy_len("busy_8n1", 40);
        n_tests++;
        if (o_user_tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_8n1: %b expected 1", o_user_tx_ready); end
        wait_frames(base + 1);
    endtask

    task automatic test_parity();
        int base;
        for (int m = 1; m <= 2; m++) begin
            base = frames_done;
            div_num = 24'd3; data_bit = 4'd7; stop_bit = 2'd0; check_bit = 2'(m);
            send(8'h41);
            busy_len(m == 1 ? "busy_odd" : "busy_even", 30);
            wait_frames(base + 1);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit got;
        base = frames_done;
        div_num = 24'd2; data_bit = 4'd8; stop_bit = 2'd2; check_bit = 2'd0;
        tx_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tx_data = (k == 0) ? 8'hA5 : 8'h3C;
            got = 0;
            for (int t = 0; t < 200 && !got; t++) begin
                if (o_user_tx_ready === 1'b1) begin
                    exp_q.push_back(make_frame(tx_data, 2, 8, 2, 0));
                    got = 1;
                end
                @(negedge clock);
            end
            if (!got) begin n_tests++; n_fail++; $display("FAIL b2b_timeout: byte %0d not accepted", k); end
        end
        tx_valid = 1'b0;
        busy_len("busy_b2b_tail", 22);
        wait_frames(base + 2);
        n_tests++;
        if (last_gap !== 1) begin n_fail++; $display("FAIL b2b_gap: %0d idle cycles, expected 1", last_gap); end
    endtask

    task automatic test_cts();
        int  base;
        int  bad_rdy;
        int  bad_tx;
        int  n;
        bit  hs;
        base = frames_done;
        div_num = 24'd4; data_bit = 4'd8; stop_bit = 2'd0; check_bit = 2'd0;
        cts = 1'b1;
        @(negedge clock);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        bad_rdy = 0;
        bad_tx = 0;
        repeat (100) begin
            @(negedge clock);
            if (o_user_tx_ready !== 1'b0) bad_rdy++;
            if (o_uart_tx !== 1'b1) bad_tx++;
        end
        n_tests += 2;
        if (bad_rdy !== 0) begin n_fail++; $display("FAIL cts_hold_ready: ready high %0d cycles, expected 0", bad_rdy); end
        if (bad_tx !== 0) begin n_fail++; $display("FAIL cts_hold_tx: TXD low %0d cycles, expected 0", bad_tx); end
        exp_q.push_back(make_frame(8'hC3, 4, 8, 0, 0));
        cts = 1'b0;
        hs = 0;
        n = 0;
        for (int t = 1; t <= 8 && n == 0; t++) begin
            @(negedge clock);
            if (hs) tx_valid = 1'b0;
            if (o_user_tx_ready === 1'b1) hs = 1;
            if (o_uart_tx === 1'b0) n = t;
        end
        tx_valid = 1'b0;
        // CTS is sampled on the first edge; the start bit follows two cycles after that.
        n_tests++;
        if (n < 1 || n > 3) begin n_fail++; $display("FAIL cts_start_delay: start after %0d cycles, expected 1..3", n); end
        cts = 1'b1;
        wait_frames(base + 1);
        @(negedge clock);
        n_tests++;
        if (o_user_tx_ready !== 1'b0) begin n_fail++; $display("FAIL cts_ready_after: %b expected 0", o_user_tx_ready); end
        cts = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (o_user_tx_ready !== 1'b1) begin n_fail++; $display("FAIL cts_release_ready: %b expected 1", o_user_tx_ready); end
    endtask

    task automatic test_clamps();
        int base;
        base = frames_done;
        div_num = 24'd0; data_bit = 4'd4; stop_bit = 2'd0; check_bit = 2'd0;
        send(8'h1F);
        busy_len("busy_div0_5bit", 7);
        wait_frames(base + 1);
        data_bit = 4'd12; stop_bit = 2'd3;
        send(8'h96);
        busy_len("busy_div0_clamp8_2stop", 11);
        wait_frames(base + 2);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        div_num = 24'd8; data_bit = 4'd8; stop_bit = 2'd0; check_bit = 2'd0;
        send(8'h00);
        repeat (13) @(negedge clock);
        n_tests++;
        if (o_uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_line: TXD=%b expected 0 in data", o_uart_tx); end
        @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        n_tests += 3;
        if (o_uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: %b expected 1", o_uart_tx); end
        if (o_user_tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: %b expected 0", o_user_tx_ready); end
        if (o_tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: %b expected 0", o_tx_busy); end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (o_user_tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release_ready: %b expected 1", o_user_tx_ready); end
        base = frames_done;
        send(8'h00);
        busy_len("busy_after_reset", 80);
        wait_frames(base + 1);
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_cts();
        test_clamps();
        test_reset_mid_frame();
        repeat (4) @(negedge clock);
        n_tests++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL leftover_frames: %0d queued, expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
